// File: rtl/id_ex_register.sv
// ---------------------------------------------------------------------------
// id_ex_register
//
// Pipeline register between the decode (ID) and execute (EX) stages of an
// in-order RISC-V style core. Besides plain capture, it owns the load-use
// hazard check. When the instruction in EX is a load and the instruction in
// decode reads that load's destination, this block asks fetch/decode to hold
// for one cycle. It also inserts a bubble into EX and counts such bubbles.
//
// Handshake / control semantics (one place, for all of them):
//   - flush_i  : the instruction entering EX is dead; load a bubble.
//   - stall_i  : EX is held externally; every e_* output and the bubble
//                counter keep their value.
//   - hazard_stall_o : combinational hold request to fetch/decode, raised
//                in the same cycle the hazard is seen and suppressed by
//                flush_i.
//   Per-edge priority: rst > flush_i > stall_i > hazard > normal load.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush_i, stall_i  kill / hold controls for the EX stage
//   d_*               decoded instruction from the ID stage
//   e_*               registered copy presented to the EX stage
//   hazard_stall_o    load-use hold request to fetch and decode
//   bubble_count      saturating count of load-use bubbles inserted
// ---------------------------------------------------------------------------
module id_ex_register #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  stall_i,

    input  logic                  d_valid,
    input  logic [2:0]            d_ALUctrl,
    input  logic [2:0]            d_ImmSrc,
    input  logic [1:0]            d_ResultSrc,
    input  logic                  d_RegWrite,
    input  logic                  d_ALUSrc,
    input  logic                  d_MemWrite,
    input  logic                  d_PcOp,
    input  logic                  d_jalr,
    input  logic                  d_branch,
    input  logic [DATA_WIDTH-1:0] d_rd1,
    input  logic [DATA_WIDTH-1:0] d_rd2,
    input  logic [DATA_WIDTH-1:0] d_pc,
    input  logic [DATA_WIDTH-1:0] d_imm,
    input  logic [4:0]            d_rs1,
    input  logic [4:0]            d_rs2,
    input  logic [4:0]            d_rd,
    input  logic [2:0]            d_funct3,

    output logic                  e_valid,
    output logic [2:0]            e_ALUctrl,
    output logic [2:0]            e_ImmSrc,
    output logic [1:0]            e_ResultSrc,
    output logic                  e_RegWrite,
    output logic                  e_ALUSrc,
    output logic                  e_MemWrite,
    output logic                  e_PcOp,
    output logic                  e_jalr,
    output logic                  e_branch,
    output logic [DATA_WIDTH-1:0] e_rd1,
    output logic [DATA_WIDTH-1:0] e_rd2,
    output logic [DATA_WIDTH-1:0] e_pc,
    output logic [DATA_WIDTH-1:0] e_imm,
    output logic [4:0]            e_rs1,
    output logic [4:0]            e_rs2,
    output logic [4:0]            e_rd,
    output logic [2:0]            e_funct3,

    output logic                  hazard_stall_o,
    output logic [15:0]           bubble_count
);

    // ResultSrc encoding that selects memory read data, i.e. a load.
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [15:0] COUNT_MAX     = 16'hFFFF;

    // Everything that travels from ID to EX, kept together so a bubble is
    // simply the all-zero value.
    typedef struct packed {
        logic                  valid;
        logic [2:0]            alu_ctrl;
        logic [2:0]            imm_src;
        logic [1:0]            result_src;
        logic                  reg_write;
        logic                  alu_src;
        logic                  mem_write;
        logic                  pc_op;
        logic                  jalr;
        logic                  branch;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [2:0]            funct3;
    } ex_t;

    ex_t         ex_q, ex_d;
    ex_t         load_w;
    logic [15:0] bubble_count_q, bubble_count_d;
    logic        hazard_w;

    // Load-use detection. A bubble in EX has valid=0 and therefore can never
    // trigger a second bubble, and a load into x0 never produces data anyone
    // waits for.
    always_comb begin
        hazard_w = ex_q.valid
                 & (ex_q.result_src == RESULT_SRC_MEM)
                 & (ex_q.rd != 5'd0)
                 & d_valid
                 & ((d_rs1 == ex_q.rd) | (d_rs2 == ex_q.rd));
    end

    assign hazard_stall_o = hazard_w & ~flush_i;

    // Normal-load value. Side-effecting control bits are gated by d_valid so
    // a non-instruction in decode can never write state or redirect the PC.
    always_comb begin
        load_w            = '0;
        load_w.valid      = d_valid;
        load_w.alu_ctrl   = d_ALUctrl;
        load_w.imm_src    = d_ImmSrc;
        load_w.result_src = d_ResultSrc;
        load_w.reg_write  = d_RegWrite & d_valid;
        load_w.alu_src    = d_ALUSrc;
        load_w.mem_write  = d_MemWrite & d_valid;
        load_w.pc_op      = d_PcOp & d_valid;
        load_w.jalr       = d_jalr & d_valid;
        load_w.branch     = d_branch & d_valid;
        load_w.rd1        = d_rd1;
        load_w.rd2        = d_rd2;
        load_w.pc         = d_pc;
        load_w.imm        = d_imm;
        load_w.rs1        = d_rs1;
        load_w.rs2        = d_rs2;
        load_w.rd         = d_rd;
        load_w.funct3     = d_funct3;
    end

    // Next-state selection in priority order (reset handled in the flop).
    always_comb begin
        ex_d           = ex_q;
        bubble_count_d = bubble_count_q;
        if (flush_i) begin
            ex_d = '0;
        end else if (stall_i) begin
            ex_d           = ex_q;
            bubble_count_d = bubble_count_q;
        end else if (hazard_w) begin
            ex_d = '0;
            if (bubble_count_q != COUNT_MAX) begin
                bubble_count_d = bubble_count_q + 16'd1;
            end
        end else begin
            ex_d = load_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q           <= '0;
            bubble_count_q <= '0;
        end else begin
            ex_q           <= ex_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign e_valid      = ex_q.valid;
    assign e_ALUctrl    = ex_q.alu_ctrl;
    assign e_ImmSrc     = ex_q.imm_src;
    assign e_ResultSrc  = ex_q.result_src;
    assign e_RegWrite   = ex_q.reg_write;
    assign e_ALUSrc     = ex_q.alu_src;
    assign e_MemWrite   = ex_q.mem_write;
    assign e_PcOp       = ex_q.pc_op;
    assign e_jalr       = ex_q.jalr;
    assign e_branch     = ex_q.branch;
    assign e_rd1        = ex_q.rd1;
    assign e_rd2        = ex_q.rd2;
    assign e_pc         = ex_q.pc;
    assign e_imm        = ex_q.imm;
    assign e_rs1        = ex_q.rs1;
    assign e_rs2        = ex_q.rs2;
    assign e_rd         = ex_q.rd;
    assign e_funct3     = ex_q.funct3;
    assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_register.sv
// ---------------------------------------------------------------------------
// tb_id_ex_register
//
// Directed, table-driven bench for id_ex_register. Each record gives the
// controls and decode payload for one cycle, the expected hazard_stall_o
// before the edge, and the expected EX payload and bubble count after it.
// Hand-written sequences afterwards cover counter saturation and reset in
// the middle of a hazard or stall.
// ---------------------------------------------------------------------------
module tb_id_ex_register;

    typedef struct packed {
        logic        valid;
        logic [2:0]  alu;
        logic [2:0]  imm_src;
        logic [1:0]  res;
        logic [5:0]  ctl;   // {RegWrite, ALUSrc, MemWrite, PcOp, jalr, branch}
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
    } pay_t;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        stall;
        pay_t        d;
        logic        exp_haz;
        pay_t        exp_e;
        logic [15:0] exp_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, flush_i, stall_i;
    logic        d_valid, d_RegWrite, d_ALUSrc, d_MemWrite, d_PcOp, d_jalr, d_branch;
    logic [2:0]  d_ALUctrl, d_ImmSrc, d_funct3;
    logic [1:0]  d_ResultSrc;
    logic [31:0] d_rd1, d_rd2, d_pc, d_imm;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic        e_valid, e_RegWrite, e_ALUSrc, e_MemWrite, e_PcOp, e_jalr, e_branch;
    logic [2:0]  e_ALUctrl, e_ImmSrc, e_funct3;
    logic [1:0]  e_ResultSrc;
    logic [31:0] e_rd1, e_rd2, e_pc, e_imm;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic        hazard_stall_o;
    logic [15:0] bubble_count;

    pay_t e_pay;
    assign e_pay = {e_valid, e_ALUctrl, e_ImmSrc, e_ResultSrc,
                    {e_RegWrite, e_ALUSrc, e_MemWrite, e_PcOp, e_jalr, e_branch},
                    e_rd1, e_rd2, e_pc, e_imm, e_rs1, e_rs2, e_rd, e_funct3};

    int total = 0;
    int bad   = 0;

    id_ex_register #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
        .d_valid(d_valid), .d_ALUctrl(d_ALUctrl), .d_ImmSrc(d_ImmSrc),
        .d_ResultSrc(d_ResultSrc), .d_RegWrite(d_RegWrite), .d_ALUSrc(d_ALUSrc),
        .d_MemWrite(d_MemWrite), .d_PcOp(d_PcOp), .d_jalr(d_jalr), .d_branch(d_branch),
        .d_rd1(d_rd1), .d_rd2(d_rd2), .d_pc(d_pc), .d_imm(d_imm),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_funct3(d_funct3),
        .e_valid(e_valid), .e_ALUctrl(e_ALUctrl), .e_ImmSrc(e_ImmSrc),
        .e_ResultSrc(e_ResultSrc), .e_RegWrite(e_RegWrite), .e_ALUSrc(e_ALUSrc),
        .e_MemWrite(e_MemWrite), .e_PcOp(e_PcOp), .e_jalr(e_jalr), .e_branch(e_branch),
        .e_rd1(e_rd1), .e_rd2(e_rd2), .e_pc(e_pc), .e_imm(e_imm),
        .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd), .e_funct3(e_funct3),
        .hazard_stall_o(hazard_stall_o), .bubble_count(bubble_count)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    function automatic pay_t mk(input logic v, input logic [2:0] alu, input logic [2:0] isrc,
                                input logic [1:0] res, input logic [5:0] ctl,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [2:0] f3);
        pay_t p;
        p = '{valid: v, alu: alu, imm_src: isrc, res: res, ctl: ctl, rd1: rd1, rd2: rd2,
              pc: pc, imm: imm, rs1: rs1, rs2: rs2, rd: rd, f3: f3};
        return p;
    endfunction

    // Driver tasks
    task automatic drive_d(input pay_t p);
        d_valid     = p.valid;
        d_ALUctrl   = p.alu;
        d_ImmSrc    = p.imm_src;
        d_ResultSrc = p.res;
        {d_RegWrite, d_ALUSrc, d_MemWrite, d_PcOp, d_jalr, d_branch} = p.ctl;
        d_rd1       = p.rd1;
        d_rd2       = p.rd2;
        d_pc        = p.pc;
        d_imm       = p.imm;
        d_rs1       = p.rs1;
        d_rs2       = p.rs2;
        d_rd        = p.rd;
        d_funct3    = p.f3;
    endtask

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check the combinational hold
    // request before the rising edge, check registered outputs at the next
    // falling edge.
    task automatic step(input string name, input vec_t v);
        rst     = v.rst;
        flush_i = v.flush;
        stall_i = v.stall;
        drive_d(v.d);
        #1;
        chk({name, ".hazard_stall_o"}, {191'd0, hazard_stall_o}, {191'd0, v.exp_haz});
        @(posedge clk);
        @(negedge clk);
        chk({name, ".e_payload"}, {31'd0, e_pay}, {31'd0, v.exp_e});
        chk({name, ".bubble_count"}, {176'd0, bubble_count}, {176'd0, v.exp_cnt});
    endtask

    function automatic vec_t mv(input logic r, input logic f, input logic s, input pay_t d,
                                input logic h, input pay_t e, input logic [15:0] c);
        vec_t v;
        v.rst = r; v.flush = f; v.stall = s; v.d = d;
        v.exp_haz = h; v.exp_e = e; v.exp_cnt = c;
        return v;
    endfunction

    pay_t z, p0, lw, add7, lw2, use7, p40, lw0, r0, inv, invg, lw6, use6, inv6, inv6g;
    vec_t vecs[18];

    initial begin
        z     = '0;
        p0    = mk(1, 3'd2, 3'd0, 2'b00, 6'b100000, 32'h1234, 32'h5678, 32'h0,  32'h0,  5'd1, 5'd2, 5'd5,  3'd0);
        lw    = mk(1, 3'd0, 3'd0, 2'b01, 6'b110000, 32'h100,  32'h0,    32'h4,  32'h8,  5'd3, 5'd0, 5'd7,  3'd2);
        add7  = mk(1, 3'd0, 3'd0, 2'b00, 6'b100000, 32'h11,   32'h22,   32'h8,  32'h0,  5'd1, 5'd7, 5'd9,  3'd0);
        lw2   = mk(1, 3'd0, 3'd0, 2'b01, 6'b110000, 32'h100,  32'h0,    32'hC,  32'h8,  5'd3, 5'd0, 5'd7,  3'd2);
        use7  = mk(1, 3'd1, 3'd0, 2'b00, 6'b100000, 32'h0,    32'h0,    32'h10, 32'h0,  5'd7, 5'd4, 5'd10, 3'd0);
        p40   = mk(1, 3'd4, 3'd2, 2'b10, 6'b100001, 32'hA,    32'hB,    32'h40, 32'h20, 5'd3, 5'd4, 5'd11, 3'd4);
        lw0   = mk(1, 3'd0, 3'd0, 2'b01, 6'b110000, 32'h200,  32'h0,    32'h50, 32'h4,  5'd2, 5'd0, 5'd0,  3'd2);
        r0    = mk(1, 3'd0, 3'd0, 2'b00, 6'b100000, 32'h1,    32'h2,    32'h54, 32'h0,  5'd0, 5'd0, 5'd12, 3'd0);
        inv   = mk(0, 3'd5, 3'd1, 2'b00, 6'b111111, 32'hAA,   32'hBB,   32'h58, 32'hCC, 5'd6, 5'd8, 5'd4,  3'd1);
        invg  = mk(0, 3'd5, 3'd1, 2'b00, 6'b010000, 32'hAA,   32'hBB,   32'h58, 32'hCC, 5'd6, 5'd8, 5'd4,  3'd1);
        lw6   = mk(1, 3'd0, 3'd0, 2'b01, 6'b110000, 32'h300,  32'h0,    32'h5C, 32'h0,  5'd1, 5'd0, 5'd6,  3'd2);
        use6  = mk(1, 3'd3, 3'd0, 2'b00, 6'b100000, 32'h5,    32'h6,    32'h60, 32'h0,  5'd6, 5'd2, 5'd13, 3'd0);
        inv6  = mk(0, 3'd3, 3'd0, 2'b00, 6'b100000, 32'h5,    32'h6,    32'h64, 32'h0,  5'd6, 5'd6, 5'd14, 3'd0);
        inv6g = mk(0, 3'd3, 3'd0, 2'b00, 6'b000000, 32'h5,    32'h6,    32'h64, 32'h0,  5'd6, 5'd6, 5'd14, 3'd0);

        //            rst flush stall d     haz  exp_e  cnt
        vecs[0]  = mv(0, 0, 0, p0,   0, p0,   16'd0);  // pass-through
        vecs[1]  = mv(0, 0, 0, lw,   0, lw,   16'd0);  // load rd=7 enters EX
        vecs[2]  = mv(0, 0, 0, add7, 1, z,    16'd1);  // rs2=7 -> bubble
        vecs[3]  = mv(0, 0, 0, add7, 0, add7, 16'd1);  // held instr now loads
        vecs[4]  = mv(0, 0, 0, lw2,  0, lw2,  16'd1);
        vecs[5]  = mv(0, 1, 0, use7, 0, z,    16'd1);  // flush beats hazard
        vecs[6]  = mv(0, 0, 0, p40,  0, p40,  16'd1);
        vecs[7]  = mv(0, 0, 1, mk(1, 3'd7, 3'd7, 2'b11, 6'b111111, 32'h1, 32'h2, 32'h44, 32'h3, 5'd11, 5'd11, 5'd1, 3'd7), 0, p40, 16'd1);
        vecs[8]  = mv(0, 0, 1, mk(0, 3'd6, 3'd5, 2'b01, 6'b000000, 32'h4, 32'h5, 32'h48, 32'h6, 5'd2,  5'd3,  5'd2, 3'd5), 0, p40, 16'd1);
        vecs[9]  = mv(0, 0, 1, mk(1, 3'd1, 3'd3, 2'b00, 6'b101010, 32'h7, 32'h8, 32'h4C, 32'h9, 5'd4,  5'd5,  5'd3, 3'd6), 0, p40, 16'd1);
        vecs[10] = mv(0, 0, 0, lw0,  0, lw0,  16'd1);  // load into x0
        vecs[11] = mv(0, 0, 0, r0,   0, r0,   16'd1);  // reads x0: no stall
        vecs[12] = mv(0, 0, 0, inv,  0, invg, 16'd1);  // invalid slot gated
        vecs[13] = mv(0, 0, 0, lw6,  0, lw6,  16'd1);
        vecs[14] = mv(0, 0, 1, use6, 1, lw6,  16'd1);  // stall wins over hazard
        vecs[15] = mv(0, 0, 0, use6, 1, z,    16'd2);  // rs1 match -> bubble
        vecs[16] = mv(0, 0, 0, lw6,  0, lw6,  16'd2);
        vecs[17] = mv(0, 0, 0, inv6, 0, inv6g, 16'd2); // invalid decode: no hazard

        rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
        drive_d(z);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.e_payload", {31'd0, e_pay}, 192'd0);
        chk("reset.bubble_count", {176'd0, bubble_count}, 192'd0);
        chk("reset.hazard_stall_o", {191'd0, hazard_stall_o}, 192'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Saturation: preload the counter near its ceiling.
        step("sat_lw0", mv(0, 0, 0, lw, 0, lw, 16'd2));
        force dut.bubble_count_q = 16'hFFFE;
        #1;
        release dut.bubble_count_q;
        step("sat_hz0", mv(0, 0, 0, add7, 1, z,  16'hFFFF));
        step("sat_lw1", mv(0, 0, 0, lw,   0, lw, 16'hFFFF));
        step("sat_hz1", mv(0, 0, 0, add7, 1, z,  16'hFFFF));

        // Reset in the middle of a hazard discards everything.
        step("rst_lw",  mv(0, 0, 0, lw,   0, lw,   16'hFFFF));
        step("rst_hz",  mv(1, 0, 0, add7, 1, z,    16'd0));
        step("rst_nxt", mv(0, 0, 0, add7, 0, add7, 16'd0));
        // Reset in the middle of an external stall.
        step("rst_stl", mv(1, 0, 1, p40,  0, z,    16'd0));
        step("rst_ld",  mv(0, 0, 0, p40,  0, p40,  16'd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the register-data, PC and immediate buses.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port flush_i, input, 1, kill the instruction entering EX (taken branch/jump resolved).
REQ-005 SHALL have port stall_i, input, 1, external hold of the EX stage (e.g. memory wait).
REQ-006 SHALL have port d_valid, input, 1, decode slot holds a real instruction.
REQ-007 SHALL have ports d_ALUctrl (3), d_ImmSrc (3), d_ResultSrc (2), inputs, decoded control fields.
REQ-008 SHALL have ports d_RegWrite, d_ALUSrc, d_MemWrite, d_PcOp, d_jalr, d_branch, inputs, 1 each, decoded control bits.
REQ-009 SHALL have ports d_rd1, d_rd2, d_pc, d_imm, inputs, DATA_WIDTH each, operands, PC and extended immediate.
REQ-010 SHALL have ports d_rs1, d_rs2, d_rd, d_funct3, inputs, 5/5/5/3, source/destination indices and funct3.
REQ-011 SHALL have outputs e_* mirroring every d_* input above (same names, e_ prefix, same widths), plus e_valid (1).
REQ-012 SHALL have port hazard_stall_o, output, 1, hold request to fetch and decode on a load-use hazard.
REQ-013 SHALL have port bubble_count, output, 16, saturating count of hazard bubbles inserted.

Function
REQ-014 SHALL compute hazard = e_valid & (e_ResultSrc==2'b01) & (e_rd!=0) & d_valid & ((d_rs1==e_rd) | (d_rs2==e_rd)), combinationally from registered state and decode inputs.
REQ-015 SHALL drive hazard_stall_o = hazard & ~flush_i in the same cycle (zero-cycle latency).
REQ-016 SHALL apply per-edge priority: rst > flush_i > stall_i > hazard > normal load.
REQ-017 On flush_i (no rst) SHALL load a bubble: e_valid=0, all control outputs 0, all data/index outputs 0.
REQ-018 On stall_i (no rst/flush_i) SHALL hold every e_* output and bubble_count unchanged.
REQ-019 On hazard (no rst/flush_i/stall_i) SHALL load a bubble as in REQ-017 and increment bubble_count.
REQ-020 On normal load SHALL capture all d_* into e_* one cycle later and set e_valid=d_valid.
REQ-021 On normal load with d_valid=0 SHALL force e_RegWrite, e_MemWrite, e_branch, e_jalr, e_PcOp to 0 regardless of inputs.
REQ-022 bubble_count SHALL saturate at 16'hFFFF and never wrap.
REQ-023 A bubble SHALL never itself cause a hazard (e_valid=0 blocks REQ-014), so a load-use costs exactly one bubble cycle.
REQ-024 Hazard on x0 (e_rd==0) SHALL NOT stall.
REQ-025 Simultaneous flush_i and hazard SHALL flush, not increment bubble_count, and deassert hazard_stall_o.

Reset
REQ-026 On rst high at a clock edge SHALL clear every e_* output, e_valid and bubble_count to 0, overriding all other inputs.
REQ-027 rst asserted mid-stall or mid-hazard SHALL discard the held instruction; first post-reset edge with d_valid=1 performs a normal load.
REQ-028 hazard_stall_o SHALL be 0 while e_valid=0, hence 0 in the cycle after reset.

Verification
REQ-029 Pass-through: d_valid=1, d_rd1=32'h1234, d_RegWrite=1, d_rd=5 -> next cycle e_rd1=32'h1234, e_RegWrite=1, e_rd=5, e_valid=1.
REQ-030 Load-use: EX holds lw rd=7 (ResultSrc=01), decode rs2=7 -> hazard_stall_o=1 that cycle, next cycle e_valid=0, bubble_count=1, following cycle instruction loads.
REQ-031 Flush vs hazard: same setup as REQ-030 plus flush_i=1 -> hazard_stall_o=0, next cycle e_valid=0, bubble_count=0.
REQ-032 Stall hold: e_pc=32'h40, stall_i=1 for 3 cycles with changing d_* -> e_pc stays 32'h40, e_valid unchanged.
REQ-033 x0 and invalid: lw rd=0 with decode rs1=0 -> no stall; d_valid=0 with d_MemWrite=1 -> e_MemWrite=0.
REQ-034 Reset/saturation: preload bubble_count=16'hFFFF, force hazard -> stays 16'hFFFF; assert rst -> all outputs 0 next cycle.
